// File: rtl/icache_refill_arbiter_if.sv
// Bundle of request, memory and response signals around the icache refill arbiter.
// The arbiter connects through the slave modport; the icache/memory side uses master.
interface icache_refill_arbiter_if #(
  parameter int PLEN   = 32,
  parameter int LINE_W = 256
);

  typedef struct packed {
    logic            valid;
    logic [PLEN-1:0] addr;
    logic            is_prefetch;
  } icache2mem_req_t;

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [LINE_W-1:0] data;
    logic              is_prefetch;
  } mem2icache_rsp_t;

  logic              dmd_valid_i;
  logic [PLEN-1:0]   dmd_addr_i;
  logic              dmd_ready_o;
  logic              pf_valid_i;
  logic [PLEN-1:0]   pf_addr_i;
  logic              pf_ready_o;
  logic              flush_i;
  icache2mem_req_t   mem_req_o;
  mem2icache_rsp_t   mem_rsp_i;
  logic              dmd_rsp_valid_o;
  logic              pf_rsp_valid_o;
  logic [PLEN-1:0]   rsp_addr_o;
  logic [LINE_W-1:0] rsp_data_o;
  logic              busy_o;

  modport slave (
    input  dmd_valid_i, dmd_addr_i, pf_valid_i, pf_addr_i, flush_i, mem_rsp_i,
    output dmd_ready_o, pf_ready_o, mem_req_o, dmd_rsp_valid_o, pf_rsp_valid_o,
           rsp_addr_o, rsp_data_o, busy_o
  );

  modport master (
    output dmd_valid_i, dmd_addr_i, pf_valid_i, pf_addr_i, flush_i, mem_rsp_i,
    input  dmd_ready_o, pf_ready_o, mem_req_o, dmd_rsp_valid_o, pf_rsp_valid_o,
           rsp_addr_o, rsp_data_o, busy_o
  );

endinterface

// File: rtl/icache_refill_arbiter.sv
// Shares the single icache refill port between demand misses and the prefetcher.
// One transaction in flight; demand wins unless a waiting prefetch has been starved
// long enough. A demand for the line a prefetch is already fetching rides along on it.
module icache_refill_arbiter #(
  parameter int PLEN      = 32,
  parameter int LINE_W    = 256,
  parameter int PF_STARVE = 8
) (
  input logic                   clk_i,
  input logic                   rst_i,
  icache_refill_arbiter_if.slave bus
);

  localparam int OFS_W = $clog2(LINE_W / 8);
  localparam int SW    = $clog2(PF_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(PF_STARVE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [PLEN-1:0]   addr_q, addr_d;
  logic              tag_d_q, tag_d_d;
  logic              tag_p_q, tag_p_d;
  logic              drop_q, drop_d;
  logic              issued_pf_q, issued_pf_d;
  logic              rsp_dmd_q, rsp_dmd_d;
  logic              rsp_pf_q, rsp_pf_d;
  logic [PLEN-1:0]   rsp_addr_q, rsp_addr_d;
  logic [LINE_W-1:0] rsp_data_q, rsp_data_d;

  logic [PLEN-1:0]   dmd_line;
  logic [PLEN-1:0]   pf_line;
  logic              force_pf;
  logic              grant_pf;
  logic              grant_dmd;
  logic              drop_now;
  logic              merge;

  assign dmd_line  = {bus.dmd_addr_i[PLEN-1:OFS_W], {OFS_W{1'b0}}};
  assign pf_line   = {bus.pf_addr_i[PLEN-1:OFS_W], {OFS_W{1'b0}}};
  assign force_pf  = bus.pf_valid_i && (starve_q == STARVE_MAX);
  assign grant_pf  = (state_q == S_IDLE) && bus.pf_valid_i && (force_pf || !bus.dmd_valid_i);
  assign grant_dmd = (state_q == S_IDLE) && bus.dmd_valid_i && !grant_pf;
  // A flush arriving in the same cycle already counts as a drop, so a demand is never
  // merged onto a transaction whose response is about to be thrown away.
  assign drop_now  = drop_q || bus.flush_i;
  assign merge     = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && tag_p_q && !tag_d_q &&
                     !drop_now && bus.dmd_valid_i && (dmd_line == addr_q);

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      addr_q      <= '0;
      tag_d_q     <= 1'b0;
      tag_p_q     <= 1'b0;
      drop_q      <= 1'b0;
      issued_pf_q <= 1'b0;
      rsp_dmd_q   <= 1'b0;
      rsp_pf_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      tag_d_q     <= tag_d_d;
      tag_p_q     <= tag_p_d;
      drop_q      <= drop_d;
      issued_pf_q <= issued_pf_d;
      rsp_dmd_q   <= rsp_dmd_d;
      rsp_pf_q    <= rsp_pf_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state logic for the FSM and the transaction bookkeeping
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    tag_d_d     = tag_d_q;
    tag_p_d     = tag_p_q;
    drop_d      = drop_q;
    issued_pf_d = issued_pf_q;
    rsp_dmd_d   = 1'b0;
    rsp_pf_d    = 1'b0;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (grant_dmd) begin
          state_d = S_ISSUE;
          addr_d  = dmd_line;
          tag_d_d = 1'b1;
          tag_p_d = 1'b0;
          if (bus.pf_valid_i && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (grant_pf) begin
          state_d  = S_ISSUE;
          addr_d   = pf_line;
          tag_d_d  = 1'b0;
          tag_p_d  = 1'b1;
          starve_d = '0;
        end
      end
      S_ISSUE: begin
        if (bus.flush_i) drop_d = 1'b1;
        if (merge) tag_d_d = 1'b1;
        if (bus.mem_rsp_i.ready) begin
          state_d     = S_WAIT;
          issued_pf_d = tag_p_q & ~tag_d_q;
        end
      end
      S_WAIT: begin
        if (bus.flush_i) drop_d = 1'b1;
        if (merge) tag_d_d = 1'b1;
        if (bus.mem_rsp_i.valid) begin
          state_d    = S_IDLE;
          rsp_dmd_d  = (tag_d_q | merge) & ~drop_now;
          rsp_pf_d   = tag_p_q & ~drop_now;
          rsp_addr_d = addr_q;
          rsp_data_d = bus.mem_rsp_i.data;
          tag_d_d    = 1'b0;
          tag_p_d    = 1'b0;
          drop_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; everything is held low while reset is asserted
  always_comb begin
    bus.dmd_ready_o     = 1'b0;
    bus.pf_ready_o      = 1'b0;
    bus.mem_req_o       = '0;
    bus.busy_o          = 1'b0;
    bus.dmd_rsp_valid_o = 1'b0;
    bus.pf_rsp_valid_o  = 1'b0;
    bus.rsp_addr_o      = rsp_addr_q;
    bus.rsp_data_o      = rsp_data_q;
    if (!rst_i) begin
      bus.busy_o          = (state_q != S_IDLE);
      bus.dmd_rsp_valid_o = rsp_dmd_q;
      bus.pf_rsp_valid_o  = rsp_pf_q;
      case (state_q)
        S_IDLE: begin
          bus.dmd_ready_o = grant_dmd;
          bus.pf_ready_o  = grant_pf;
        end
        S_ISSUE: begin
          bus.dmd_ready_o           = merge;
          bus.mem_req_o.valid       = 1'b1;
          bus.mem_req_o.addr        = addr_q;
          bus.mem_req_o.is_prefetch = tag_p_q & ~tag_d_q;
        end
        S_WAIT: begin
          bus.dmd_ready_o = merge;
        end
        default: ;
      endcase
    end
  end

  // Memory must only answer while a response is expected
  a_rsp_in_wait : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.mem_rsp_i.valid |-> (state_q == S_WAIT));

  // The returned prefetch flag must echo the one that went out with the request
  a_rsp_kind : assert property (@(posedge clk_i) disable iff (rst_i)
    ((state_q == S_WAIT) && bus.mem_rsp_i.valid) |-> (bus.mem_rsp_i.is_prefetch == issued_pf_q));

endmodule

// File: tb/tb_icache_refill_arbiter.sv
// Directed testbench for icache_refill_arbiter: one task per scenario with inline checks.
module tb_icache_refill_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  icache_refill_arbiter_if #(.PLEN(32), .LINE_W(256)) bus ();

  icache_refill_arbiter #(.PLEN(32), .LINE_W(256), .PF_STARVE(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory side of one transaction, starting in an ISSUE cycle: ready after rdly
  // cycles, response vdly cycles after the ready cycle. Returns in the pulse cycle.
  task automatic mem_serve(input int rdly, input int vdly, input logic [255:0] data, input logic pf);
    for (int i = 0; i < rdly; i++) tick();
    bus.mem_rsp_i.ready = 1'b1;
    tick();
    bus.mem_rsp_i.ready = 1'b0;
    for (int i = 1; i < vdly; i++) tick();
    bus.mem_rsp_i.valid       = 1'b1;
    bus.mem_rsp_i.data        = data;
    bus.mem_rsp_i.is_prefetch = pf;
    tick();
    bus.mem_rsp_i.valid       = 1'b0;
    bus.mem_rsp_i.is_prefetch = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.dmd_valid_i = 1'b1;
    bus.dmd_addr_i  = 32'h0000_1000;
    tick();
    tick();
    checks++; if (bus.dmd_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_dmd_ready got %b exp 0", bus.dmd_ready_o); end
    checks++; if (bus.mem_req_o.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_valid got %b exp 0", bus.mem_req_o.valid); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", bus.busy_o); end
    checks++; if ({bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b exp 00", {bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o}); end
    checks++; if (bus.rsp_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_addr got %h exp 0", bus.rsp_addr_o); end
    checks++; if (bus.rsp_data_o !== 256'h0) begin errors++; $display("[TB] FAIL reset_rsp_data got %h exp 0", bus.rsp_data_o); end
    checks++; if (dut.starve_q !== 4'd0) begin errors++; $display("[TB] FAIL reset_starve got %0d exp 0", dut.starve_q); end
    bus.dmd_valid_i = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_demand_refill();
    logic [255:0] d;
    d = {8{32'hDEAD_0001}};
    bus.dmd_valid_i = 1'b1;
    bus.dmd_addr_i  = 32'h8000_0044;
    #1;
    checks++; if (bus.dmd_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL t1_dmd_ready got %b exp 1", bus.dmd_ready_o); end
    tick();
    bus.dmd_valid_i = 1'b0;
    checks++; if (bus.mem_req_o.valid !== 1'b1) begin errors++; $display("[TB] FAIL t1_req_valid got %b exp 1", bus.mem_req_o.valid); end
    checks++; if (bus.mem_req_o.addr !== 32'h8000_0040) begin errors++; $display("[TB] FAIL t1_req_addr got %h exp 80000040", bus.mem_req_o.addr); end
    checks++; if (bus.mem_req_o.is_prefetch !== 1'b0) begin errors++; $display("[TB] FAIL t1_req_pf got %b exp 0", bus.mem_req_o.is_prefetch); end
    tick();
    checks++; if ({bus.mem_req_o.valid, bus.mem_req_o.addr} !== {1'b1, 32'h8000_0040}) begin errors++; $display("[TB] FAIL t1_req_hold got %b/%h exp 1/80000040", bus.mem_req_o.valid, bus.mem_req_o.addr); end
    bus.mem_rsp_i.ready = 1'b1;
    tick();
    bus.mem_rsp_i.ready = 1'b0;
    checks++; if ({bus.mem_req_o.valid, bus.busy_o} !== 2'b01) begin errors++; $display("[TB] FAIL t1_wait_state got valid/busy %b exp 01", {bus.mem_req_o.valid, bus.busy_o}); end
    tick();
    tick();
    bus.mem_rsp_i.valid       = 1'b1;
    bus.mem_rsp_i.data        = d;
    bus.mem_rsp_i.is_prefetch = 1'b0;
    #1;
    checks++; if (bus.dmd_rsp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL t1_rsp_early got %b exp 0", bus.dmd_rsp_valid_o); end
    tick();
    bus.mem_rsp_i.valid = 1'b0;
    checks++; if ({bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o} !== 2'b10) begin errors++; $display("[TB] FAIL t1_rsp_pulse got %b exp 10", {bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o}); end
    checks++; if (bus.rsp_data_o !== d) begin errors++; $display("[TB] FAIL t1_rsp_data got %h exp %h", bus.rsp_data_o, d); end
    checks++; if (bus.rsp_addr_o !== 32'h8000_0040) begin errors++; $display("[TB] FAIL t1_rsp_addr got %h exp 80000040", bus.rsp_addr_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL t1_busy_end got %b exp 0", bus.busy_o); end
    tick();
    checks++; if (bus.dmd_rsp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL t1_pulse_width got %b exp 0", bus.dmd_rsp_valid_o); end
  endtask

  task automatic test_priority();
    bus.dmd_valid_i = 1'b1;
    bus.dmd_addr_i  = 32'h0000_1000;
    bus.pf_valid_i  = 1'b1;
    bus.pf_addr_i   = 32'h0000_3000;
    #1;
    checks++; if ({bus.dmd_ready_o, bus.pf_ready_o} !== 2'b10) begin errors++; $display("[TB] FAIL t2_grant got %b exp 10", {bus.dmd_ready_o, bus.pf_ready_o}); end
    tick();
    bus.dmd_valid_i = 1'b0;
    #1;
    checks++; if (bus.pf_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL t2_pf_ready_busy got %b exp 0", bus.pf_ready_o); end
    mem_serve(0, 1, {8{32'h0000_2222}}, 1'b0);
    checks++; if ({bus.dmd_rsp_valid_o, bus.pf_ready_o} !== 2'b11) begin errors++; $display("[TB] FAIL t2_pf_next got rsp/ready %b exp 11", {bus.dmd_rsp_valid_o, bus.pf_ready_o}); end
    tick();
    bus.pf_valid_i = 1'b0;
    checks++; if ({bus.mem_req_o.is_prefetch, bus.mem_req_o.addr} !== {1'b1, 32'h0000_3000}) begin errors++; $display("[TB] FAIL t2_pf_req got %b/%h exp 1/00003000", bus.mem_req_o.is_prefetch, bus.mem_req_o.addr); end
    mem_serve(0, 1, {8{32'h0000_3333}}, 1'b1);
    checks++; if ({bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o} !== 2'b01) begin errors++; $display("[TB] FAIL t2_pf_rsp got %b exp 01", {bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o}); end
    tick();
  endtask

  task automatic test_starvation();
    bus.dmd_valid_i = 1'b1;
    bus.dmd_addr_i  = 32'h0000_2000;
    bus.pf_valid_i  = 1'b1;
    bus.pf_addr_i   = 32'h0000_3000;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (i < 8) begin
        checks++; if ({bus.dmd_ready_o, bus.pf_ready_o} !== 2'b10) begin errors++; $display("[TB] FAIL t3_grant_%0d got %b exp 10", i, {bus.dmd_ready_o, bus.pf_ready_o}); end
      end else begin
        checks++; if ({bus.dmd_ready_o, bus.pf_ready_o} !== 2'b01) begin errors++; $display("[TB] FAIL t3_grant_%0d got %b exp 01", i, {bus.dmd_ready_o, bus.pf_ready_o}); end
      end
      tick();
      if (i == 7) begin
        checks++; if (dut.starve_q !== 4'd8) begin errors++; $display("[TB] FAIL t3_starve_sat got %0d exp 8", dut.starve_q); end
      end
      if (i == 8) begin
        checks++; if (dut.starve_q !== 4'd0) begin errors++; $display("[TB] FAIL t3_starve_clr got %0d exp 0", dut.starve_q); end
      end
      mem_serve(0, 1, {8{i}}, (i == 8));
      checks++; if ({bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o} !== ((i == 8) ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL t3_rsp_%0d got %b exp %b", i, {bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o}, ((i == 8) ? 2'b01 : 2'b10)); end
    end
    bus.dmd_valid_i = 1'b0;
    bus.pf_valid_i  = 1'b0;
    tick();
  endtask

  task automatic test_merge_wait();
    logic [255:0] d;
    d = {8{32'hCAFE_0100}};
    bus.pf_valid_i = 1'b1;
    bus.pf_addr_i  = 32'h0000_0100;
    #1;
    checks++; if (bus.pf_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL t4_pf_ready got %b exp 1", bus.pf_ready_o); end
    tick();
    bus.pf_valid_i = 1'b0;
    checks++; if ({bus.mem_req_o.is_prefetch, bus.mem_req_o.addr} !== {1'b1, 32'h0000_0100}) begin errors++; $display("[TB] FAIL t4_req got %b/%h exp 1/00000100", bus.mem_req_o.is_prefetch, bus.mem_req_o.addr); end
    bus.mem_rsp_i.ready = 1'b1;
    tick();
    bus.mem_rsp_i.ready = 1'b0;
    bus.dmd_valid_i = 1'b1;
    bus.dmd_addr_i  = 32'h0000_011C;
    #1;
    checks++; if (bus.dmd_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL t4_merge_ready got %b exp 1", bus.dmd_ready_o); end
    tick();
    bus.dmd_valid_i = 1'b0;
    checks++; if (bus.mem_req_o.valid !== 1'b0) begin errors++; $display("[TB] FAIL t4_no_reissue got %b exp 0", bus.mem_req_o.valid); end
    bus.mem_rsp_i.valid       = 1'b1;
    bus.mem_rsp_i.data        = d;
    bus.mem_rsp_i.is_prefetch = 1'b1;
    tick();
    bus.mem_rsp_i.valid       = 1'b0;
    bus.mem_rsp_i.is_prefetch = 1'b0;
    checks++; if ({bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o} !== 2'b11) begin errors++; $display("[TB] FAIL t4_both_pulse got %b exp 11", {bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o}); end
    checks++; if (bus.rsp_data_o !== d) begin errors++; $display("[TB] FAIL t4_data got %h exp %h", bus.rsp_data_o, d); end
    checks++; if (bus.rsp_addr_o !== 32'h0000_0100) begin errors++; $display("[TB] FAIL t4_addr got %h exp 00000100", bus.rsp_addr_o); end
    tick();
    checks++; if ({bus.mem_req_o.valid, bus.busy_o} !== 2'b00) begin errors++; $display("[TB] FAIL t4_single_txn got %b exp 00", {bus.mem_req_o.valid, bus.busy_o}); end
  endtask

  task automatic test_merge_issue();
    bus.pf_valid_i = 1'b1;
    bus.pf_addr_i  = 32'h0000_0200;
    tick();
    bus.pf_valid_i  = 1'b0;
    bus.dmd_valid_i = 1'b1;
    bus.dmd_addr_i  = 32'h0000_0204;
    #1;
    checks++; if ({bus.dmd_ready_o, bus.mem_req_o.is_prefetch} !== 2'b11) begin errors++; $display("[TB] FAIL t4b_merge got ready/pf %b exp 11", {bus.dmd_ready_o, bus.mem_req_o.is_prefetch}); end
    tick();
    bus.dmd_valid_i = 1'b0;
    checks++; if ({bus.mem_req_o.valid, bus.mem_req_o.is_prefetch} !== 2'b10) begin errors++; $display("[TB] FAIL t4b_pf_cleared got valid/pf %b exp 10", {bus.mem_req_o.valid, bus.mem_req_o.is_prefetch}); end
    mem_serve(0, 2, {8{32'h0000_0200}}, 1'b0);
    checks++; if ({bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o} !== 2'b11) begin errors++; $display("[TB] FAIL t4b_both_pulse got %b exp 11", {bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o}); end
    tick();
  endtask

  task automatic test_flush();
    bus.dmd_valid_i = 1'b1;
    bus.dmd_addr_i  = 32'h0000_0400;
    tick();
    bus.dmd_valid_i     = 1'b0;
    bus.mem_rsp_i.ready = 1'b1;
    tick();
    bus.mem_rsp_i.ready = 1'b0;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.mem_rsp_i.valid       = 1'b1;
    bus.mem_rsp_i.data        = {8{32'hBAD0_0400}};
    bus.mem_rsp_i.is_prefetch = 1'b0;
    tick();
    bus.mem_rsp_i.valid = 1'b0;
    checks++; if ({bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o} !== 2'b00) begin errors++; $display("[TB] FAIL t5_suppressed got %b exp 00", {bus.dmd_rsp_valid_o, bus.pf_rsp_valid_o}); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL t5_idle got %b exp 0", bus.busy_o); end
    bus.dmd_valid_i = 1'b1;
    bus.dmd_addr_i  = 32'h0000_0500;
    bus.flush_i     = 1'b1;
    #1;
    checks++; if (bus.dmd_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL t5_next_accept got %b exp 1", bus.dmd_ready_o); end
    tick();
    bus.dmd_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    checks++; if (bus.mem_req_o.addr !== 32'h0000_0500) begin errors++; $display("[TB] FAIL t5_next_addr got %h exp 00000500", bus.mem_req_o.addr); end
    mem_serve(1, 1, {8{32'h0000_0500}}, 1'b0);
    checks++; if (bus.dmd_rsp_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL t5_idle_flush_ignored got %b exp 1", bus.dmd_rsp_valid_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.dmd_valid_i = 1'b1;
    bus.dmd_addr_i  = 32'h0000_1000;
    bus.pf_valid_i  = 1'b1;
    bus.pf_addr_i   = 32'h0000_3000;
    tick();
    bus.dmd_valid_i = 1'b0;
    bus.pf_valid_i  = 1'b0;
    checks++; if (dut.starve_q !== 4'd1) begin errors++; $display("[TB] FAIL t6_starve_pre got %0d exp 1", dut.starve_q); end
    rst = 1'b1;
    tick();
    checks++; if ({bus.mem_req_o.valid, bus.busy_o} !== 2'b00) begin errors++; $display("[TB] FAIL t6_rst_outputs got %b exp 00", {bus.mem_req_o.valid, bus.busy_o}); end
    checks++; if (dut.starve_q !== 4'd0) begin errors++; $display("[TB] FAIL t6_starve got %0d exp 0", dut.starve_q); end
    rst = 1'b0;
    tick();
    checks++; if ({bus.mem_req_o.valid, bus.busy_o} !== 2'b00) begin errors++; $display("[TB] FAIL t6_after_rst got %b exp 00", {bus.mem_req_o.valid, bus.busy_o}); end
  endtask

  // Hard time limit so a stuck run still reports and ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.dmd_valid_i = 1'b0;
    bus.dmd_addr_i  = '0;
    bus.pf_valid_i  = 1'b0;
    bus.pf_addr_i   = '0;
    bus.flush_i     = 1'b0;
    bus.mem_rsp_i   = '0;
    test_reset();
    test_demand_refill();
    test_priority();
    test_starvation();
    test_merge_wait();
    test_merge_issue();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
